tri_wave_tracker: RTL and testbench



---
 rtl/tri_wave_tracker.sv | 228 ++++++++++++++++++++++
 tb/tb_tri_wave_tracker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tri_wave_tracker.sv
// ---------------------------------------------------------------------------
// tri_wave_tracker
//
// Receive-side monitor for the LO..HI..LO up/down triangle counter. Watches
// a qualified sample stream, locks onto the ping-pong pattern, reports the
// recovered direction and phase, and flags every sample that breaks the
// predicted sequence. A saturating 8-bit counter accumulates the errors.
//
// Ports:
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   sample_valid  in   qualifies sample; low cycles hold all state
//   sample        in   observed counter value [WIDTH-1:0]
//   err_clr       in   synchronous clear of err_count
//   locked        out  tracker is following the pattern (state != HUNT)
//   dir           out  1 = rising, 0 = falling (valid when locked)
//   phase         out  position in period, 0..2*(HI-LO)-1 (valid when locked)
//   err           out  one-cycle pulse per mismatching sample
//   err_count     out  saturating error count
//
// Optional build macro: TRI_WAVE_TRACKER_FORMAL_EN compiles in assertions
// and an input assume for formal use. Logic is identical either way.
//
// FSM states:
//   state  | meaning
//   HUNT   | searching for two consecutive samples one step apart
//   UP     | locked, counter rising toward HI
//   DOWN   | locked, counter falling toward LO
// ---------------------------------------------------------------------------
module tri_wave_tracker #(
    parameter  int WIDTH = 8,
    parameter  int LO    = 150,
    parameter  int HI    = 160,
    localparam int PW    = $clog2(2*(HI-LO))
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             err_clr,
    output logic             locked,
    output logic             dir,
    output logic [PW-1:0]    phase,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    // All value arithmetic is one bit wider than the sample so that
    // prev+1 / prev-1 can never alias an in-range value.
    localparam logic [WIDTH:0] C_LO    = (WIDTH+1)'(LO);
    localparam logic [WIDTH:0] C_HI    = (WIDTH+1)'(HI);
    localparam logic [WIDTH:0] C_SPAN2 = (WIDTH+1)'(2*(HI-LO));

    logic [1:0]       r_state;
    logic             r_have_prev;
    logic [WIDTH-1:0] r_prev;
    logic             r_dir;
    logic [PW-1:0]    r_phase;
    logic             r_err;
    logic [7:0]       r_err_count;

    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_p;
    logic [WIDTH:0]   w_p_inc;
    logic [WIDTH:0]   w_p_dec;
    logic             w_in_range;
    logic             w_locked;
    logic [WIDTH:0]   w_expect;
    logic             w_next_rising;
    logic             w_match;
    logic [WIDTH:0]   w_off;
    logic [WIDTH:0]   w_ph_rise;
    logic [WIDTH:0]   w_ph_fall;
    logic             w_err_now;

    assign w_s        = {1'b0, sample};
    assign w_p        = {1'b0, r_prev};
    assign w_p_inc    = w_p + 1'b1;
    assign w_p_dec    = w_p - 1'b1;
    assign w_in_range = (w_s >= C_LO) && (w_s <= C_HI);
    assign w_locked   = (r_state == S_UP) || (r_state == S_DOWN);

    // Predicted next value and the direction it implies, including the
    // turnaround at each end of the triangle.
    always_comb begin
        w_expect      = w_p_inc;
        w_next_rising = 1'b1;
        case (r_state)
            S_UP: begin
                if (w_p == C_HI) begin
                    w_expect      = C_HI - 1'b1;
                    w_next_rising = 1'b0;
                end else begin
                    w_expect      = w_p_inc;
                    w_next_rising = 1'b1;
                end
            end
            S_DOWN: begin
                if (w_p == C_LO) begin
                    w_expect      = C_LO + 1'b1;
                    w_next_rising = 1'b1;
                end else begin
                    w_expect      = w_p_dec;
                    w_next_rising = 1'b0;
                end
            end
            default: begin
                w_expect      = w_p_inc;
                w_next_rising = 1'b1;
            end
        endcase
    end

    assign w_match   = (w_s == w_expect) && w_in_range;
    assign w_err_now = sample_valid && w_locked && !w_match;

    // Falling LO would otherwise land on 2*(HI-LO); it is the period start.
    assign w_off     = w_s - C_LO;
    assign w_ph_rise = w_off;
    assign w_ph_fall = (w_off == '0) ? '0 : (C_SPAN2 - w_off);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_HUNT;
            r_have_prev <= 1'b0;
            r_prev      <= '0;
            r_dir       <= 1'b0;
            r_phase     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (sample_valid) begin
                case (r_state)
                    S_UP, S_DOWN: begin
                        if (w_match) begin
                            r_prev  <= sample;
                            r_state <= w_next_rising ? S_UP : S_DOWN;
                            r_dir   <= w_next_rising;
                            r_phase <= w_next_rising ? w_ph_rise[PW-1:0]
                                                     : w_ph_fall[PW-1:0];
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_HUNT;
                            if (w_in_range) begin
                                r_prev      <= sample;
                                r_have_prev <= 1'b1;
                            end else begin
                                r_have_prev <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        if (!w_in_range) begin
                            r_have_prev <= 1'b0;
                            r_state     <= S_HUNT;
                        end else if (!r_have_prev) begin
                            r_prev      <= sample;
                            r_have_prev <= 1'b1;
                            r_state     <= S_HUNT;
                        end else if (w_s == w_p_inc) begin
                            r_prev  <= sample;
                            r_state <= S_UP;
                            r_dir   <= 1'b1;
                            r_phase <= w_ph_rise[PW-1:0];
                        end else if (w_s == w_p_dec) begin
                            r_prev  <= sample;
                            r_state <= S_DOWN;
                            r_dir   <= 1'b0;
                            r_phase <= w_ph_fall[PW-1:0];
                        end else begin
                            r_prev  <= sample;
                            r_state <= S_HUNT;
                        end
                    end
                endcase
            end
        end
    end

    // A clear that coincides with an error keeps that error counted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_count <= 8'd0;
        end else if (w_err_now) begin
            if (err_clr)
                r_err_count <= 8'd1;
            else if (r_err_count != 8'hFF)
                r_err_count <= r_err_count + 8'd1;
        end else if (err_clr) begin
            r_err_count <= 8'd0;
        end
    end

    assign locked    = w_locked;
    assign dir       = r_dir;
    assign phase     = r_phase;
    assign err       = r_err;
    assign err_count = r_err_count;

`ifdef TRI_WAVE_TRACKER_FORMAL_EN
    a_locked_state: assert property (@(posedge clk)
        locked == (r_state != S_HUNT));

    a_phase_range: assert property (@(posedge clk)
        int'(phase) < 2*(HI-LO));

    a_prev_in_range: assert property (@(posedge clk)
        locked |-> ((w_p >= C_LO) && (w_p <= C_HI)));

    a_err_cause: assert property (@(posedge clk) disable iff (!resetn)
        err |-> $past(sample_valid && w_locked));

    a_dir_phase: assert property (@(posedge clk)
        dir |-> (int'(phase) <= (HI-LO)));

    a_cnt_monotonic: assert property (@(posedge clk) disable iff (!resetn)
        !$past(err_clr) |-> (err_count >= $past(err_count)));

    // Restrict the environment to a legal generator trace while locked.
    m_legal_trace: assume property (@(posedge clk) disable iff (!resetn)
        (w_locked && sample_valid) |-> w_match);
`endif

endmodule

// File: tb/tb_tri_wave_tracker.sv
module tb_tri_wave_tracker;

    logic       clk;
    logic       resetn;
    logic       sample_valid;
    logic [7:0] sample;
    logic       err_clr;
    logic       locked;
    logic       dir;
    logic [4:0] phase;
    logic       err;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    tri_wave_tracker #(.WIDTH(8), .LO(150), .HI(160)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample),
        .err_clr      (err_clr),
        .locked       (locked),
        .dir          (dir),
        .phase        (phase),
        .err          (err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] s;
        logic       c;
        logic       lk;
        logic       dr;
        logic [4:0] ph;
        logic       er;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] s, input logic c,
                                input logic lk, input logic dr, input logic [4:0] ph,
                                input logic er, input logic [7:0] cnt);
        vec_t t;
        t.v = v; t.s = s; t.c = c; t.lk = lk; t.dr = dr; t.ph = ph; t.er = er; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lk, input int dr, input int ph,
                           input int er, input int cnt);
        chk({tag, ".locked"}, int'(locked), lk);
        chk({tag, ".dir"}, int'(dir), dr);
        chk({tag, ".phase"}, int'(phase), ph);
        chk({tag, ".err"}, int'(err), er);
        chk({tag, ".err_count"}, int'(err_count), cnt);
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic c);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        err_clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int v;
        int exp_cnt;

        resetn       = 1'b0;
        sample_valid = 1'b0;
        sample       = 8'd0;
        err_clr      = 1'b0;

        // Three full periods starting at LO; position k gives the phase.
        for (int n = 0; n < 62; n++) begin
            k = n % 20;
            v = (k <= 10) ? (150 + k) : (170 - k);
            tbl.push_back(mk(1'b1, 8'(v), 1'b0, n > 0, (n > 0) && (k >= 1) && (k <= 10),
                             (n == 0) ? 5'd0 : 5'(k), 1'b0, 8'd0));
        end
        tbl.push_back(mk(1, 152, 0, 1, 1, 2, 0, 0));
        tbl.push_back(mk(1, 155, 0, 0, 1, 2, 1, 1));   // skip 153
        tbl.push_back(mk(1, 156, 0, 1, 1, 6, 0, 1));   // relock
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 1, 1, 6, 0, 1)); // idle: frozen
        tbl.push_back(mk(1, 157, 0, 1, 1, 7, 0, 1));
        tbl.push_back(mk(1, 200, 0, 0, 1, 7, 1, 2));   // out of range while locked
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 0, 2));     // idle forces err low
        tbl.push_back(mk(1, 158, 0, 0, 1, 7, 0, 2));   // no relock alone
        tbl.push_back(mk(1, 200, 0, 0, 1, 7, 0, 2));   // out of range in HUNT
        tbl.push_back(mk(1, 159, 0, 0, 1, 7, 0, 2));
        tbl.push_back(mk(1, 160, 0, 1, 1, 10, 0, 2));
        tbl.push_back(mk(1, 159, 1, 1, 0, 11, 0, 0));  // clear alone
        tbl.push_back(mk(1, 158, 0, 1, 0, 12, 0, 0));

        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].c);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].lk), int'(tbl[i].dr),
                    int'(tbl[i].ph), int'(tbl[i].er), int'(tbl[i].cnt));
        end

        // 256 errors: alternate a bad sample and a relocking sample.
        for (int i = 1; i <= 256; i++) begin
            exp_cnt = (i > 255) ? 255 : i;
            step(1'b1, 8'd150, 1'b0);
            chk($sformatf("sat%0d.err", i), int'(err), 1);
            chk($sformatf("sat%0d.cnt", i), int'(err_count), exp_cnt);
            step(1'b1, 8'd151, 1'b0);
            chk($sformatf("sat%0d.relock", i), int'(locked), 1);
        end
        step(1'b1, 8'd150, 1'b1);
        chk_all("clr_err", 0, 1, 1, 1, 1);

        step(1'b1, 8'd151, 1'b0);
        step(1'b1, 8'd152, 1'b0);
        chk_all("pre_rst", 1, 1, 2, 0, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        step(1'b1, 8'd160, 1'b0);
        chk_all("hi_first", 0, 0, 0, 0, 0);
        step(1'b1, 8'd159, 1'b0);
        chk_all("hi_pair", 1, 0, 11, 0, 0);
        step(1'b1, 8'd151, 1'b0);
        chk_all("jump", 0, 0, 11, 1, 1);
        step(1'b1, 8'd150, 1'b0);
        chk_all("lock_down_lo", 1, 0, 0, 0, 1);
        step(1'b1, 8'd151, 1'b0);
        chk_all("turn_lo", 1, 1, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
